// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   rx_state_t  - 3-bit receiver state encoding
//   bit_period  - clocks per bit for a given clock frequency and baud rate
//   parity_bit  - expected parity bit for a data byte and parity select
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_FLUSH  = 3'd5
  } rx_state_t;

  // The +1 matches the transmitter's bit timing, so TX and RX in the same
  // clock domain agree cycle for cycle.
  function automatic int bit_period(input int clk_hz, input int baud);
    return clk_hz / baud + 1;
  endfunction

  // sel=1 gives the XOR of the data bits, sel=0 its complement.
  function automatic logic parity_bit(input logic [7:0] data, input logic sel);
    return sel ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for a single asynchronous input.
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset; both flops load p_rst_val
//   d_i    - asynchronous input
//   q_o    - synchronized output
module uart_sync2 #(
  parameter logic p_rst_val = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= p_rst_val;
      q_o  <= p_rst_val;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8 data bits LSB first, optional
// parity, one or two stop bits.
//   clk_i         - system clock
//   rst_i         - asynchronous active-high reset
//   rx_i          - serial line, idle high, asynchronous to clk_i
//   parity_en_i   - a parity bit follows the data bits
//   parity_sel_i  - parity type (see uart_pkg::parity_bit)
//   stop_sel_i    - 0: one stop bit, 1: two stop bits
//   data_o        - last received byte, held until the next strobe
//   data_valid_o  - one-cycle strobe when data_o and error flags update
//   parity_err_o  - parity mismatch, qualified by data_valid_o
//   frame_err_o   - a stop sample was low, qualified by data_valid_o
//   busy_o        - receiver is not idle
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle, waiting for synchronized rx low
// ST_START  | half a bit in, confirming the start bit (high = glitch)
// ST_DATA   | sampling 8 data bits, one per bit period
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling one or two stop bits, strobe after the last
// ST_FLUSH  | break / stuck-low line, waiting for rx high
module uart_rx
  import uart_pkg::*;
#(
  parameter int p_clk_speed_hz = 50_000_000,
  parameter int p_baud_rate    = 9_600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       parity_en_i,
  input  logic       parity_sel_i,
  input  logic       stop_sel_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int P  = bit_period(p_clk_speed_hz, p_baud_rate);
  localparam int CW = $clog2(P) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(P);
  localparam logic [CW-1:0] HALF_CNT = CW'(P / 2);

  logic rxs;

  uart_sync2 #(
    .p_rst_val(1'b1)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (rx_i),
    .q_o  (rxs)
  );

  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_en_q, par_en_d;
  logic            par_sel_q, par_sel_d;
  logic            stop_sel_q, stop_sel_d;
  logic            stop_more_q, stop_more_d;
  logic            par_err_q, par_err_d;
  logic            frm_err_q, frm_err_d;
  logic            done;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_sel_d   = par_sel_q;
    stop_sel_d  = stop_sel_q;
    stop_more_d = stop_more_q;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          // Configuration is frozen here so mid-frame changes are ignored.
          cnt_d      = '0;
          par_en_d   = parity_en_i;
          par_sel_d  = parity_sel_i;
          stop_sel_d = stop_sel_i;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        cnt_d = cnt_inc;
        if (cnt_inc == HALF_CNT) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            bit_cnt_d = 3'd0;
            state_d   = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        cnt_d = cnt_inc;
        if (cnt_inc == FULL_CNT) begin
          cnt_d              = '0;
          shift_d[bit_cnt_q] = rxs;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            stop_more_d = stop_sel_q;
            state_d     = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        cnt_d = cnt_inc;
        if (cnt_inc == FULL_CNT) begin
          cnt_d     = '0;
          par_err_d = (rxs != parity_bit(shift_q, par_sel_q));
          state_d   = ST_STOP;
        end
      end

      ST_STOP: begin
        cnt_d = cnt_inc;
        if (cnt_inc == FULL_CNT) begin
          cnt_d = '0;
          if (!rxs) frm_err_d = 1'b1;
          if (stop_more_q) begin
            stop_more_d = 1'b0;
          end else begin
            done    = 1'b1;
            // A low final stop sample means a break or stuck line: do not
            // re-arm on it, wait for the line to return high first.
            state_d = rxs ? ST_IDLE : ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (rxs) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_en_q    <= 1'b0;
      par_sel_q   <= 1'b0;
      stop_sel_q  <= 1'b0;
      stop_more_q <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      par_sel_q   <= par_sel_d;
      stop_sel_q  <= stop_sel_d;
      stop_more_q <= stop_more_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
    end
  end

  // Byte and status flags are published together with the strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o       <= 8'h00;
      data_valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      data_valid_o <= done;
      if (done) begin
        data_o       <= shift_q;
        parity_err_o <= par_en_q & par_err_q;
        frame_err_o  <= frm_err_d;
      end
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule
